sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO, the successor of the fixed synchronous FIFO. Width, depth and thresholds are set by parameters, and the block selects between registered-read and first-word-fall-through (FWFT) output modes. It also reports occupancy, almost-full/almost-empty and overflow/underflow error pulses. It sits between a producer and a consumer in the same clock domain, and the existing `fifo_if` is extended with the new signals.

## Interface
- `DATA_WIDTH`, 8, width of each data word.
- `DEPTH`, 16, number of entries; must be a power of two, at least 2.
- `AF_THRESH`, DEPTH-2, `almost_full` asserts when count >= AF_THRESH; legal range 1..DEPTH.
- `AE_THRESH`, 2, `almost_empty` asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- `FWFT`, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `w_en`  in  1  write request.
- `r_en`  in  1  read request.
- `data_in`  in  DATA_WIDTH  write data.
- `data_out`  out  DATA_WIDTH  read data.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count >= AF_THRESH.
- `almost_empty`  out  1  count <= AE_THRESH.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse: a write was rejected.
- `underflow`  out  1  one-cycle pulse: a read was rejected.

## Operation
- Pointers:
  - `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_W+1).
  - full: the address bits are equal and the wrap bits differ. empty: the pointers are equal.
- Write acceptance: `w_en && !full`, where `full` is the value before the edge. An accepted write stores `data_in` at wr_ptr and increments wr_ptr.
- Read acceptance: `r_en && !empty`, where `empty` is the value before the edge. An accepted read increments rd_ptr.
- Rejected writes: `w_en && full` does not change wr_ptr or memory. `overflow` is high for the next cycle.
- Rejected reads: `r_en && empty` does not change rd_ptr or `data_out`. `underflow` is high for the next cycle.
- Simultaneous write and read:
  - Full: the read is accepted and the write is rejected (overflow pulse). Count becomes DEPTH-1.
  - Empty: the write is accepted and the read is rejected (underflow pulse). Count becomes 1. This holds in FWFT mode as well.
  - Otherwise both are accepted and count is unchanged.
- FWFT=0: `data_out` is registered. It loads mem[rd_ptr] on an accepted read and holds otherwise.
- FWFT=1: `data_out` = mem[rd_ptr] combinationally whenever !empty, and is 0 when empty. An accepted read pops the word being displayed.
- Wrap-around: pointers wrap naturally at 2^(ADDR_W+1). No data is lost across the wrap.
- Reset (asynchronous assert, synchronous release):
  - Pointers and `count` go to 0.
  - `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0, `data_out`=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored words immediately.

## Timing
- Flags and count are derived from the registered pointers. They reflect the state after the edge that applied the request.
- Write latency:
  - FWFT=0: a word written at edge N is readable by an r_en at edge N+1. `data_out` updates at edge N+1.
  - FWFT=1: the word written at edge N is visible on `data_out` after edge N.
- Error pulses are registered and last exactly one cycle per offending request. Back-to-back offences give a continuously high pulse.
- No combinational path exists from `w_en`/`r_en` to any output.

## Structure
- Package `sync_fifo_pkg`:
  - default constants `FIFO_DEF_WIDTH`=8 and `FIFO_DEF_DEPTH`=16;
  - function `fifo_addr_w(depth)` returning $clog2(depth).
- Sub-module `sync_fifo_mem`: DEPTH x DATA_WIDTH array with one synchronous write port and one asynchronous read port. The top holds the pointers, flags, error logic and output register.
- Parameter legality is checked with elaboration-time assertions: DEPTH must be a power of two, and the thresholds must be in range.

## Test plan
- Reset defaults: DATA_WIDTH=8, DEPTH=16, FWFT=0. Hold rst low for 2 cycles → `empty`=1, `almost_empty`=1, `count`=0, `data_out`=0, `full`=0, `overflow`=0, `underflow`=0.
- Fill and overflow:
  - Write 0x01..0x10 → after the 14th write `almost_full`=1; after the 16th, `full`=1 and `count`=16.
  - A 17th write → `overflow`=1 for one cycle; count stays 16.
- Drain and underflow: read all 16 entries → `data_out` = 0x01..0x10 in order, each one cycle after its r_en. A further read → `underflow`=1, `data_out` holds 0x10.
- Wrap-around: write 10, read 10, write 12, read 12 → the data order is preserved across the pointer wrap, and `count` returns to 0.
- Simultaneous events:
  - Full with w_en and r_en together → count 15, `overflow`=1.
  - Empty with both together → count 1, `underflow`=1.
  - Half-full with both together → count unchanged.
- FWFT=1:
  - Write 0xA5 to an empty FIFO → `data_out`=0xA5 after that edge, with no r_en.
  - Assert reset mid-fill at count 5 → `empty`=1 and `count`=0 immediately.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = FIFO_DEF_WIDTH,
  parameter  int DEPTH      = FIFO_DEF_DEPTH,
  localparam int ADDR_W     = fifo_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Contents are deliberately not reset; validity is tracked by the pointers.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered or fall-through read,
// occupancy, almost flags and registered overflow/underflow pulses.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH      = FIFO_DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_en,
  input  logic                          r_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [fifo_addr_w(DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int ADDR_W = fifo_addr_w(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_T = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end
  if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // Flags come only from registered pointers, so no request-to-output path.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      overflow  <= w_en && full;
      underflow <= r_en && empty;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : rd_data;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= rd_data;
      end
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench: one registered-read and one FWFT instance.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst, rst_f;
  logic       w_en, r_en, w_en_f, r_en_f;
  logic [7:0] data_in, data_in_f;
  logic [7:0] data_out, data_out_f;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic       full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
  logic [4:0] count, count_f;

  int errors = 0;
  int checks = 0;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst_f), .w_en(w_en_f), .r_en(r_en_f), .data_in(data_in_f),
    .data_out(data_out_f), .full(full_f), .empty(empty_f),
    .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
    .overflow(overflow_f), .underflow(underflow_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rst_f = 1'b0;
    w_en = 1'b0; r_en = 1'b0; data_in = '0;
    w_en_f = 1'b0; r_en_f = 1'b0; data_in_f = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset defaults
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_f_empty", empty_f, 1);
    chk("rst_f_dout", data_out_f, 0);
    rst = 1'b1; rst_f = 1'b1;

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      w_en = 1'b1; data_in = 8'(i);
      tick();
      if (i == 2)  chk("ae_at2", almost_empty, 1);
      if (i == 3)  chk("ae_at3", almost_empty, 0);
      if (i == 13) chk("af_at13", almost_full, 0);
      if (i == 14) chk("af_at14", almost_full, 1);
      if (i == 15) chk("full_at15", full, 0);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);

    data_in = 8'h11;
    tick();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    w_en = 1'b0;
    tick();
    chk("ovf_clear", overflow, 0);
    chk("ovf_dout_hold", data_out, 0);

    // drain
    for (int i = 1; i <= 16; i++) begin
      r_en = 1'b1;
      tick();
      chk("drain_data", data_out, i);
      if (i == 1) chk("drain_not_full", full, 0);
    end
    chk("drain_empty", empty, 1);
    tick();
    chk("unf_pulse", underflow, 1);
    chk("unf_dout_hold", data_out, 8'h10);
    chk("unf_count", count, 0);
    r_en = 1'b0;
    tick();
    chk("unf_clear", underflow, 0);

    // wrap-around: 10 in/out, then 12 across the pointer wrap
    for (int i = 0; i < 10; i++) begin
      w_en = 1'b1; data_in = 8'(8'h20 + i);
      tick();
    end
    w_en = 1'b0;
    chk("wrap_count10", count, 10);
    for (int i = 0; i < 10; i++) begin
      r_en = 1'b1;
      tick();
      chk("wrap_data_a", data_out, 8'h20 + i);
    end
    r_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      w_en = 1'b1; data_in = 8'(8'h40 + i);
      tick();
    end
    w_en = 1'b0;
    chk("wrap_count12", count, 12);
    for (int i = 0; i < 12; i++) begin
      r_en = 1'b1;
      tick();
      chk("wrap_data_b", data_out, 8'h40 + i);
    end
    r_en = 1'b0;
    chk("wrap_count0", count, 0);
    chk("wrap_empty", empty, 1);

    // simultaneous at full
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; data_in = 8'(8'h60 + i);
      tick();
    end
    chk("sim_full_pre", full, 1);
    r_en = 1'b1; data_in = 8'hEE;
    tick();
    chk("sim_full_count", count, 15);
    chk("sim_full_ovf", overflow, 1);
    chk("sim_full_dout", data_out, 8'h60);
    w_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("sim_drain_data", data_out, 8'h60 + i);
    end
    chk("sim_drain_empty", empty, 1);

    // simultaneous at empty
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h77;
    tick();
    chk("sim_empty_count", count, 1);
    chk("sim_empty_unf", underflow, 1);
    chk("sim_empty_dout", data_out, 8'h6F);
    r_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_in = 8'(8'h78 + i);
      tick();
    end
    chk("half_count_pre", count, 8);

    // simultaneous at half full
    r_en = 1'b1; data_in = 8'h7F;
    tick();
    chk("sim_half_count", count, 8);
    chk("sim_half_dout", data_out, 8'h77);
    chk("sim_half_ovf", overflow, 0);
    chk("sim_half_unf", underflow, 0);
    w_en = 1'b0; r_en = 1'b0;

    // FWFT instance
    w_en_f = 1'b1; data_in_f = 8'hA5;
    tick();
    chk("fwft_dout_a5", data_out_f, 8'hA5);
    chk("fwft_not_empty", empty_f, 0);
    w_en_f = 1'b0; r_en_f = 1'b1;
    tick();
    chk("fwft_pop_empty", empty_f, 1);
    chk("fwft_pop_dout0", data_out_f, 0);
    w_en_f = 1'b1; data_in_f = 8'h11;
    tick();
    chk("fwft_sim_count", count_f, 1);
    chk("fwft_sim_unf", underflow_f, 1);
    chk("fwft_sim_dout", data_out_f, 8'h11);
    r_en_f = 1'b0; data_in_f = 8'h22;
    tick();
    w_en_f = 1'b0; r_en_f = 1'b1;
    tick();
    chk("fwft_next_word", data_out_f, 8'h22);
    chk("fwft_next_count", count_f, 1);
    r_en_f = 1'b0; w_en_f = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      data_in_f = 8'(i * 8'h11);
      tick();
    end
    w_en_f = 1'b0;
    chk("fwft_count5", count_f, 5);
    chk("fwft_head", data_out_f, 8'h22);

    // asynchronous reset mid-fill
    #2 rst_f = 1'b0;
    #1;
    chk("async_rst_empty", empty_f, 1);
    chk("async_rst_count", count_f, 0);
    chk("async_rst_dout", data_out_f, 0);
    tick();
    rst_f = 1'b1;
    tick();
    chk("post_rst_count", count_f, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
